// File: rtl/fp32_mul_pipe.sv
// fp32_mul_pipe: four-stage pipelined IEEE-754 binary32 multiplier (flush-to-zero, round-nearest-even, canonical NaN)
// Ports:
//   clk, rst            clock; synchronous active-high reset clearing every stage, rst overrides en
//   en                  advance enable; 0 freezes every stage register and ignores inputs
//   in_valid, in_a/b    operand pair captured on an enabled edge
//   out_valid           registered result valid, three enabled edges after capture
//   out_result          binary32 product
//   out_flags           {invalid, overflow, underflow, inexact}, forced to 0 for bubbles
module fp32_mul_pipe #(
   parameter int          LATENCY   = 4,
   parameter logic [31:0] CANON_NAN = 32'h7FC00000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        in_valid,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   output logic        out_valid,
   output logic [31:0] out_result,
   output logic [3:0]  out_flags
);
   typedef struct packed {
      logic nan;
      logic snan;
      logic inf_zero;
      logic inf;
      logic zero;
   } cls_t;

   if (LATENCY != 4) begin : g_latency_check
      $error("fp32_mul_pipe: only LATENCY=4 is implemented");
   end

   logic [7:0]        ea, eb;
   logic [22:0]       fa, fb;
   logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   cls_t              c1_d;
   logic signed [9:0] e1_d;

   assign ea     = in_a[30:23];
   assign eb     = in_b[30:23];
   assign fa     = in_a[22:0];
   assign fb     = in_b[22:0];
   // exp=0 covers both true zero and subnormals, which are flushed
   assign a_zero = ea == 8'd0;
   assign b_zero = eb == 8'd0;
   assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
   assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
   assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
   assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);
   assign c1_d   = {a_nan | b_nan,
                    (a_nan & ~fa[22]) | (b_nan & ~fb[22]),
                    (a_inf & b_zero) | (a_zero & b_inf),
                    a_inf | b_inf,
                    a_zero | b_zero};
   // ten bits keep ea+eb-127 (range -125..381) and the later +2 from wrapping
   assign e1_d   = {2'b00, ea} + {2'b00, eb} - 10'd127;

   logic              s1_valid, s1_sign;
   logic signed [9:0] s1_exp;
   logic [23:0]       s1_ma, s1_mb;
   cls_t              s1_cls;

   logic              s2_valid, s2_sign;
   logic signed [9:0] s2_exp;
   logic [47:0]       s2_prod;
   cls_t              s2_cls;

   logic              s3_valid, s3_sign, s3_inexact;
   logic signed [9:0] s3_exp;
   logic [22:0]       s3_mant;
   cls_t              s3_cls;

   logic              hi, g, r, st, up;
   logic [23:0]       sig;
   logic [24:0]       rnd;
   logic signed [9:0] e3_d;

   // a product of two [1,2) significands lies in [1,4); bit47 selects the binade
   assign hi   = s2_prod[47];
   assign sig  = hi ? s2_prod[47:24] : s2_prod[46:23];
   assign g    = hi ? s2_prod[23] : s2_prod[22];
   assign r    = hi ? s2_prod[22] : s2_prod[21];
   assign st   = hi ? |s2_prod[21:0] : |s2_prod[20:0];
   assign up   = g & (r | st | sig[0]);
   assign rnd  = {1'b0, sig} + {24'd0, up};
   assign e3_d = s2_exp + {9'd0, hi} + {9'd0, rnd[24]};

   logic        ovf, unf;
   logic [31:0] res4;
   logic [3:0]  flags4;

   assign ovf    = s3_exp >= 10'sd255;
   assign unf    = s3_exp <= 10'sd0;
   assign res4   = s3_cls.nan      ? CANON_NAN :
                   s3_cls.inf_zero ? CANON_NAN :
                   s3_cls.inf      ? {s3_sign, 8'hFF, 23'd0} :
                   s3_cls.zero     ? {s3_sign, 31'd0} :
                   ovf             ? {s3_sign, 8'hFF, 23'd0} :
                   unf             ? {s3_sign, 31'd0} :
                                     {s3_sign, s3_exp[7:0], s3_mant};
   assign flags4 = s3_cls.nan      ? {s3_cls.snan, 3'b000} :
                   s3_cls.inf_zero ? 4'b1000 :
                   (s3_cls.inf | s3_cls.zero) ? 4'b0000 :
                   ovf             ? 4'b0101 :
                   unf             ? 4'b0011 :
                                     {3'b000, s3_inexact};

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid   <= 1'b0;
         s1_sign    <= 1'b0;
         s1_exp     <= '0;
         s1_ma      <= '0;
         s1_mb      <= '0;
         s1_cls     <= '0;
         s2_valid   <= 1'b0;
         s2_sign    <= 1'b0;
         s2_exp     <= '0;
         s2_prod    <= '0;
         s2_cls     <= '0;
         s3_valid   <= 1'b0;
         s3_sign    <= 1'b0;
         s3_exp     <= '0;
         s3_mant    <= '0;
         s3_inexact <= 1'b0;
         s3_cls     <= '0;
         out_valid  <= 1'b0;
         out_result <= '0;
         out_flags  <= '0;
      end else if (en) begin
         s1_valid   <= in_valid;
         s1_sign    <= in_a[31] ^ in_b[31];
         s1_exp     <= e1_d;
         s1_ma      <= {1'b1, fa};
         s1_mb      <= {1'b1, fb};
         s1_cls     <= c1_d;
         s2_valid   <= s1_valid;
         s2_sign    <= s1_sign;
         s2_exp     <= s1_exp;
         s2_prod    <= s1_ma * s1_mb;
         s2_cls     <= s1_cls;
         s3_valid   <= s2_valid;
         s3_sign    <= s2_sign;
         s3_exp     <= e3_d;
         // on a rounding carry rnd is 1_000..0, so its low 23 bits are already the renormalised mantissa
         s3_mant    <= rnd[22:0];
         s3_inexact <= g | r | st;
         s3_cls     <= s2_cls;
         out_valid  <= s3_valid;
         out_result <= res4;
         out_flags  <= s3_valid ? flags4 : 4'b0000;
      end
   end
endmodule

// File: tb/tb_fp32_mul_pipe.sv
// tb_fp32_mul_pipe: directed and randomised checks of the pipelined binary32 multiplier
module tb_fp32_mul_pipe;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic        out_valid;
   logic [31:0] out_result;
   logic [3:0]  out_flags;

   int          n_vec = 0;
   int          n_err = 0;
   int          k;
   logic [35:0] q[$];
   logic [31:0] fk [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                           32'h40800000, 32'h40A00000, 32'h40C00000};
   logic [31:0] ra, rb;
   logic        rv, re;

   fp32_mul_pipe dut (
      .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_result(out_result), .out_flags(out_flags)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b);
      in_valid = v;
      in_a     = a;
      in_b     = b;
   endtask

   task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic run1(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic [3:0] ef);
      drive(1'b1, a, b);
      tick;
      drive(1'b0, '0, '0);
      tick;
      tick;
      tick;
      chk(tag, {out_valid, out_flags, out_result}, {1'b1, ef, er});
      tick;
      chk({tag, "_bubble"}, {out_valid, out_flags}, '0);
   endtask

   function automatic logic [31:0] rand_op();
      logic s;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
         0: return {s, 31'd0};
         1: return {s, 8'hFF, 23'd0};
         2: return {s, 8'hFF, 1'b1, 22'($urandom)};
         3: return {s, 8'hFF, 1'b0, 22'($urandom_range(1, 22'h3FFFFF))};
         4: return {s, 8'h00, 23'($urandom_range(1, 23'h7FFFFF))};
         5: return {s, ($urandom_range(0, 1) != 0) ? 8'($urandom_range(1, 3)) : 8'($urandom_range(252, 254)), 23'($urandom)};
         default: return {s, 8'($urandom_range(1, 254)), 23'($urandom)};
      endcase
   endfunction

   // FTZ/RNE reference: normalise the 48-bit product to bit 47, then compare the discarded half against one half-ulp
   function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      int          ea, eb, e;
      logic [22:0] fa, fb;
      logic        s, na, nb, ia, ib, za, zb, up;
      logic [47:0] p;
      logic [23:0] keep, rem;
      logic [24:0] k25;
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      fa = a[22:0];
      fb = b[22:0];
      s  = a[31] ^ b[31];
      na = ea == 255 && fa != 0;
      nb = eb == 255 && fb != 0;
      ia = ea == 255 && fa == 0;
      ib = eb == 255 && fb == 0;
      za = ea == 0;
      zb = eb == 0;
      if (na || nb) return {(na && !fa[22]) || (nb && !fb[22]), 3'b000, 32'h7FC00000};
      if ((ia && zb) || (za && ib)) return {4'b1000, 32'h7FC00000};
      if (ia || ib) return {4'b0000, s, 31'h7F800000};
      if (za || zb) return {4'b0000, s, 31'd0};
      p = {1'b1, fa} * {1'b1, fb};
      e = ea + eb - 127;
      if (p[47]) e++;
      else p = p << 1;
      keep = p[47:24];
      rem  = p[23:0];
      up   = (rem > 24'h800000) || (rem == 24'h800000 && keep[0]);
      k25  = {1'b0, keep} + {24'd0, up};
      if (k25[24]) begin
         e++;
         k25 = k25 >> 1;
      end
      if (e >= 255) return {4'b0101, s, 31'h7F800000};
      if (e <= 0) return {4'b0011, s, 31'd0};
      return {3'b000, rem != 0, s, e[7:0], k25[22:0]};
   endfunction

   initial begin
      tick;
      tick;
      rst = 1'b0;
      chk("reset_state", {out_valid, out_flags, out_result}, '0);

      drive(1'b1, 32'h3FC00000, 32'h40000000);
      tick;
      drive(1'b0, '0, '0);
      chk("lat_edge1", {out_valid}, '0);
      tick;
      chk("lat_edge2", {out_valid}, '0);
      tick;
      chk("lat_edge3", {out_valid}, '0);
      tick;
      chk("lat_edge4", {out_valid, out_flags, out_result}, {1'b1, 4'b0000, 32'h40400000});
      tick;
      chk("lat_bubble", {out_valid, out_flags}, '0);

      run1("inexact_lsb",  32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001);
      run1("inf_times_0",  32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000);
      run1("overflow",     32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101);
      run1("underflow",    32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011);
      run1("neg_min_norm", 32'h80800000, 32'h7F000000, 32'hC0000000, 4'b0000);
      run1("tie_up",       32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001);
      run1("tie_down",     32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'b0001);
      run1("round_carry",  32'h3FFFFFFE, 32'h3F800001, 32'h40000000, 4'b0001);
      run1("snan",         32'h7FA00000, 32'h3F800000, 32'h7FC00000, 4'b1000);
      run1("qnan",         32'hFFC00001, 32'h40000000, 32'h7FC00000, 4'b0000);
      run1("subnorm_inf",  32'h00000001, 32'h7F800000, 32'h7FC00000, 4'b1000);
      run1("neg_inf",      32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000);
      run1("neg_zero",     32'h80000000, 32'h40400000, 32'h80000000, 4'b0000);

      k = 0;
      for (int t = 1; t <= 11; t++) begin
         en = !(t == 4 || t == 5);
         if (!en) drive(1'b1, 32'h7F800000, 32'h00000000);
         else if (k < 6) begin
            drive(1'b1, fk[k], 32'h3F800000);
            k++;
         end else drive(1'b0, '0, '0);
         tick;
         if (t >= 6) chk($sformatf("stream_t%0d", t), {out_valid, out_flags, out_result}, {1'b1, 4'b0000, fk[t-6]});
         else chk($sformatf("stream_t%0d", t), {out_valid, out_flags}, '0);
      end
      en = 1'b1;

      drive(1'b1, 32'h40400000, 32'h40000000);
      tick;
      drive(1'b0, '0, '0);
      tick;
      tick;
      tick;
      chk("hold_out", {out_valid, out_flags, out_result}, {1'b1, 4'b0000, 32'h40C00000});
      en = 1'b0;
      drive(1'b1, 32'h7F800000, 32'h00000000);
      tick;
      chk("hold_stall1", {out_valid, out_flags, out_result}, {1'b1, 4'b0000, 32'h40C00000});
      tick;
      chk("hold_stall2", {out_valid, out_flags, out_result}, {1'b1, 4'b0000, 32'h40C00000});
      en = 1'b1;
      drive(1'b0, '0, '0);
      tick;
      chk("hold_resume", {out_valid, out_flags}, '0);

      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h3FC00000, 32'h40000000);
         tick;
      end
      drive(1'b0, '0, '0);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("flush_rst", {out_valid, out_flags, out_result}, '0);
      for (int i = 1; i <= 5; i++) begin
         tick;
         chk($sformatf("flush_c%0d", i), {out_valid, out_flags}, '0);
      end

      for (int i = 0; i < 10004; i++) begin
         ra = rand_op();
         rb = rand_op();
         rv = (i < 10000) && ($urandom_range(0, 3) != 0);
         re = (i >= 10000) || ($urandom_range(0, 7) != 0);
         en = re;
         drive(rv, ra, rb);
         tick;
         if (re && rv) q.push_back(ref_mul(ra, rb));
         if (re && out_valid) begin
            if (q.size() == 0) chk("rand_extra", {out_valid}, '0);
            else chk($sformatf("rand_%0d", i), {out_flags, out_result}, q.pop_front());
         end else if (re) chk("rand_bubble_flags", {out_flags}, '0);
      end
      chk("rand_drain", q.size(), '0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
